// File: rtl/mem_arbiter_ifetch.sv
// mem_arbiter_ifetch
//   Owns the single byte-wide main-memory port and shares it between the
//   instruction-fetch path and the load/store unit. Fetches look up the
//   instruction cache first; a miss reads four bytes from RAM, refills the
//   cache through ic_update and returns the word. Loads and stores move
//   1, 2 or 4 bytes, little-endian, one byte per cycle.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (low freezes the block)
//   if_req/if_addr/if_flush  -> if_ready/if_data      fetch interface
//   ic_addr -> ic_hit/ic_data, ic_update/_addr/_data  instruction cache
//   ls_req/ls_we/ls_addr/ls_width/ls_wdata -> ls_ready/ls_rdata   LSU
//   mem_din -> mem_dout/mem_a/mem_wr                  external RAM
//
// Optional feature
//   IFETCH_PERF_CNT_EN: adds perf_hit/perf_miss counters of accepted fetch
//   hit and miss grants.
//
// RAM timing: the address presented in one cycle returns its byte on
// mem_din in the next, so a read of n bytes spends n+1 cycles in the read
// state (cnt = 0..n); byte cnt-1 is captured while cnt = 1..n.
module mem_arbiter_ifetch #(
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [31:0]       if_data,
    output logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_hit,
    input  logic [31:0]       ic_data,
    output logic              ic_update,
    output logic [ADDR_W-1:0] ic_update_addr,
    output logic [31:0]       ic_update_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [1:0]        ls_width,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ready,
    output logic [31:0]       ls_rdata,
    input  logic [BYTE_W-1:0] mem_din,
    output logic [BYTE_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_hit,
    output logic [31:0]       perf_miss
`endif
);

    typedef enum logic [2:0] {
        IDLE, IF_HIT, IF_READ, IF_DONE, LS_READ, LS_WRITE, LS_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic [2:0]        len_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       word_reg;
    logic              last_ls_reg;
    logic              flush_reg;

    logic              fetch_want;
    logic              take_ls, take_hit, take_miss, capture;
    logic [2:0]        ls_len;
    logic [1:0]        cap_idx;

    // A fetch that arrives together with a flush is dropped before arbitration.
    assign fetch_want = if_req && !if_flush;
    assign ls_len     = (ls_width == 2'b00) ? 3'd1 : (ls_width == 2'b01) ? 3'd2 : 3'd4;
    assign cap_idx    = 2'(cnt_reg - 3'd1);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        take_ls    = 1'b0;
        take_hit   = 1'b0;
        take_miss  = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                // LSU wins a tie unless it also won the previous grant.
                if (ls_req && (!fetch_want || !last_ls_reg)) begin
                    take_ls    = 1'b1;
                    cnt_next   = 3'd0;
                    state_next = ls_we ? LS_WRITE : LS_READ;
                end else if (fetch_want) begin
                    if (ic_hit) begin
                        take_hit   = 1'b1;
                        state_next = IF_HIT;
                    end else begin
                        take_miss  = 1'b1;
                        cnt_next   = 3'd0;
                        state_next = IF_READ;
                    end
                end
            end
            IF_HIT: state_next = IDLE;
            IF_READ, LS_READ: begin
                capture = (cnt_reg != 3'd0);
                if (cnt_reg == len_reg)
                    state_next = (state_reg == IF_READ) ? IF_DONE : LS_DONE;
                else
                    cnt_next = cnt_reg + 3'd1;
            end
            LS_WRITE: begin
                if (cnt_reg == len_reg - 3'd1)
                    state_next = LS_DONE;
                else
                    cnt_next = cnt_reg + 3'd1;
            end
            IF_DONE, LS_DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg   <= IDLE;
            cnt_reg     <= 3'd0;
            len_reg     <= 3'd0;
            base_reg    <= '0;
            wdata_reg   <= '0;
            word_reg    <= '0;
            last_ls_reg <= 1'b0;
            flush_reg   <= 1'b0;
        end else if (rdy_in) begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (take_ls) begin
                last_ls_reg <= 1'b1;
                base_reg    <= ls_addr;
                wdata_reg   <= ls_wdata;
                len_reg     <= ls_len;
                word_reg    <= '0;      // zero-extension of short loads
            end
            if (take_hit) begin
                last_ls_reg <= 1'b0;
                word_reg    <= ic_data;
            end
            if (take_miss) begin
                last_ls_reg <= 1'b0;
                base_reg    <= if_addr;
                len_reg     <= 3'd4;
                word_reg    <= '0;
                flush_reg   <= 1'b0;
            end
            if (capture)
                word_reg[BYTE_W*cap_idx +: BYTE_W] <= mem_din;
            // A flush during the refill only cancels the reply, not the refill.
            if (state_reg == IF_READ && if_flush)
                flush_reg <= 1'b1;
        end
    end

    // Completion strobes are qualified with rdy_in so a frozen DONE state
    // cannot be seen as more than one handshake.
    assign if_ready = rdy_in && ((state_reg == IF_HIT) ||
                                 (state_reg == IF_DONE && !flush_reg && !if_flush));
    assign ls_ready = rdy_in && (state_reg == LS_DONE);
    assign ic_update      = rdy_in && (state_reg == IF_DONE);
    assign ic_update_addr = ic_update ? base_reg : '0;
    assign ic_update_data = ic_update ? word_reg : '0;
    assign if_data  = word_reg;
    assign ls_rdata = word_reg;
    assign ic_addr  = if_addr;

    assign mem_a    = (state_reg == IF_READ || state_reg == LS_READ || state_reg == LS_WRITE)
                      ? base_reg + ADDR_W'(cnt_reg) : '0;
    assign mem_wr   = rdy_in && (state_reg == LS_WRITE);
    assign mem_dout = (state_reg == LS_WRITE) ? wdata_reg[BYTE_W*cnt_reg[1:0] +: BYTE_W] : '0;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_hit_reg, perf_miss_reg;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            perf_hit_reg  <= '0;
            perf_miss_reg <= '0;
        end else if (rdy_in) begin
            if (take_hit)
                perf_hit_reg <= perf_hit_reg + 32'd1;
            if (take_miss)
                perf_miss_reg <= perf_miss_reg + 32'd1;
        end
    end

    assign perf_hit  = perf_hit_reg;
    assign perf_miss = perf_miss_reg;
`endif

endmodule

// File: tb/tb_mem_arbiter_ifetch.sv
// Self-checking bench for mem_arbiter_ifetch.
// Environment: a synchronous byte RAM and a small instruction cache that
// fills from ic_update. Expectations come from a transaction-level model:
// a byte array mirroring memory contents, a per-word "cached" flag and
// latency rules (hit 1, miss 6, load n+2, store n+1, plus stall cycles).
module tb_mem_arbiter_ifetch;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        if_req, if_flush, if_ready;
    logic [31:0] if_addr, if_data, ic_addr;
    logic        ic_hit, ic_update;
    logic [31:0] ic_data, ic_update_addr, ic_update_data;
    logic        ls_req, ls_we, ls_ready;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [1:0]  ls_width;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_hit, perf_miss;
`endif

    always #5 clk_in = ~clk_in;

    mem_arbiter_ifetch dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_data(if_data),
        .ic_addr(ic_addr), .ic_hit(ic_hit), .ic_data(ic_data),
        .ic_update(ic_update), .ic_update_addr(ic_update_addr), .ic_update_data(ic_update_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_width(ls_width),
        .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
`ifdef IFETCH_PERF_CNT_EN
        , .perf_hit(perf_hit), .perf_miss(perf_miss)
`endif
    );

    // ---------------- environment: RAM and instruction cache ----------------
    logic [7:0]  ram      [0:16383];
    logic [31:0] ic_line  [0:63];
    logic        ic_valid [0:63];

    always @(posedge clk_in) begin
        if (rdy_in) begin
            mem_din <= ram[mem_a[13:0]];
            if (mem_wr) ram[mem_a[13:0]] <= mem_dout;
        end
        if (ic_update) begin
            ic_line[ic_update_addr[7:2]]  <= ic_update_data;
            ic_valid[ic_update_addr[7:2]] <= 1'b1;
        end
    end

    assign ic_hit  = ic_valid[ic_addr[7:2]] && (ic_addr[31:8] == 24'h000001);
    assign ic_data = ic_line[ic_addr[7:2]];

    // ---------------- reference model ----------------
    logic [7:0] ref_mem    [0:16383];
    bit         ref_cached [0:63];
    int         n_hit, n_miss;
    int         errors, checks;

    typedef struct {
        int          kind;      // 0 fetch, 1 load, 2 store
        logic [31:0] addr;
        logic [1:0]  width;
        logic [31:0] wdata;
        int          flush_at;  // cycle index of a one-cycle flush, 0 = none
        int          stall_at;
        int          stall_len;
        logic [31:0] exp_data;
        int          exp_lat;   // cycle index of the ready pulse
    } vec_t;

    function automatic vec_t mk(int kind, logic [31:0] addr, logic [1:0] width, logic [31:0] wdata,
                                int flush_at, int stall_at, int stall_len,
                                logic [31:0] exp_data, int exp_lat);
        vec_t v;
        v.kind = kind; v.addr = addr; v.width = width; v.wdata = wdata;
        v.flush_at = flush_at; v.stall_at = stall_at; v.stall_len = stall_len;
        v.exp_data = exp_data; v.exp_lat = exp_lat;
        return v;
    endfunction

    function automatic int nbytes(logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] addr, int n);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            a = addr + 32'(k);
            w = w | (32'(ref_mem[a[13:0]]) << (8 * k));
        end
        return w;
    endfunction

    task automatic chk32(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int id, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn %0d: got %b expected %b", name, id, act, exp);
        end
    endtask

    // One requester at a time; DUT is idle at entry (called at posedge+1).
    task automatic run_txn(input vec_t t, input int id);
        int  e, n;
        bit  r, miss, flushed, fin;
        n = (t.kind == 0) ? 4 : nbytes(t.width);
        miss = (t.kind == 0) && !ref_cached[t.addr[7:2]];
        e = 0; flushed = 0; fin = 0;
        if (t.kind == 0) begin
            if_req = 1'b1; if_addr = t.addr;
        end else begin
            ls_req = 1'b1; ls_we = (t.kind == 2); ls_addr = t.addr;
            ls_width = t.width; ls_wdata = t.wdata;
        end
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            r = !(t.stall_len > 0 && cyc >= t.stall_at && cyc < t.stall_at + t.stall_len);
            rdy_in = r;
            if (t.flush_at > 0 && cyc == t.flush_at) begin
                if_flush = 1'b1; if_req = 1'b0; flushed = 1;
            end else begin
                if_flush = 1'b0;
            end
            @(negedge clk_in);
            if (cyc == 0 && t.kind == 0) chk32("ic_addr", id, ic_addr, t.addr);
            chk1("if_ready", id, if_ready, t.kind == 0 && cyc == t.exp_lat && !flushed);
            chk1("ls_ready", id, ls_ready, t.kind != 0 && cyc == t.exp_lat);
            chk1("ic_update", id, ic_update, miss && cyc == t.exp_lat);
            chk1("mem_wr", id, mem_wr, t.kind == 2 && r && e >= 1 && e <= n);
            if ((t.kind != 0 || miss) && e >= 1 && e <= n)
                chk32("mem_a", id, mem_a, t.addr + 32'(e - 1));
            if (t.kind == 2 && e >= 1 && e <= n)
                chk32("mem_dout", id, {24'b0, mem_dout}, (t.wdata >> (8 * (e - 1))) & 32'hFF);
            if (cyc == t.exp_lat) begin
                if (t.kind == 0 && !flushed) chk32("if_data", id, if_data, t.exp_data);
                if (miss) begin
                    chk32("ic_update_addr", id, ic_update_addr, t.addr);
                    chk32("ic_update_data", id, ic_update_data, t.exp_data);
                end
                if (t.kind == 1) chk32("ls_rdata", id, ls_rdata, t.exp_data);
                fin = 1;
            end
            if (r) e++;
            @(posedge clk_in); #1;
        end
        if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0; rdy_in = 1'b1;
        if (t.kind == 0) begin
            if (miss) begin n_miss++; ref_cached[t.addr[7:2]] = 1; end
            else n_hit++;
        end
        if (t.kind == 2)
            for (int k = 0; k < n; k++) begin
                logic [31:0] a;
                a = t.addr + 32'(k);
                ref_mem[a[13:0]] = t.wdata[8*k +: 8];
            end
        $display("txn %0d kind=%0d addr=%h lat=%0d", id, t.kind, t.addr, t.exp_lat);
    endtask

    // Fetch miss and load requested in the same cycle.
    task automatic dual(input int id, input logic [31:0] faddr, input logic [31:0] fexp, input int flat,
                        input logic [31:0] laddr, input logic [1:0] lw, input logic [31:0] lexp, input int llat);
        int last;
        last = (flat > llat) ? flat : llat;
        if_req = 1'b1; if_addr = faddr;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = laddr; ls_width = lw;
        for (int cyc = 0; cyc <= last; cyc++) begin
            @(negedge clk_in);
            chk1("dual if_ready", id, if_ready, cyc == flat);
            chk1("dual ic_update", id, ic_update, cyc == flat);
            chk1("dual ls_ready", id, ls_ready, cyc == llat);
            chk1("dual mem_wr", id, mem_wr, 1'b0);
            if (cyc == flat) begin
                chk32("dual if_data", id, if_data, fexp);
                chk32("dual ic_update_data", id, ic_update_data, fexp);
                chk32("dual ic_update_addr", id, ic_update_addr, faddr);
            end
            if (cyc == llat) chk32("dual ls_rdata", id, ls_rdata, lexp);
            @(posedge clk_in); #1;
            if (cyc == flat) if_req = 1'b0;
            if (cyc == llat) ls_req = 1'b0;
        end
        ref_cached[faddr[7:2]] = 1;
        n_miss++;
        $display("txn %0d dual fetch=%h@%0d load=%h@%0d", id, faddr, flat, laddr, llat);
    endtask

    vec_t vt [10];

    initial begin
        errors = 0; checks = 0; n_hit = 0; n_miss = 0;
        for (int i = 0; i < 16384; i++) begin
            ram[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        ram[256] = 8'h13; ram[257] = 8'h05; ram[258] = 8'h00; ram[259] = 8'h00;
        ram[260] = 8'h93; ram[261] = 8'h05; ram[262] = 8'h10; ram[263] = 8'h00;
        for (int i = 256; i < 264; i++) ref_mem[i] = ram[i];
        for (int i = 0; i < 64; i++) begin ic_valid[i] = 1'b0; ref_cached[i] = 0; end

        vt[0] = mk(0, 32'h100,  2'd0, 32'h0,      0, 0, 0, 32'h00000513, 6);
        vt[1] = mk(0, 32'h100,  2'd0, 32'h0,      0, 0, 0, 32'h00000513, 1);
        vt[2] = mk(2, 32'h2000, 2'd1, 32'hBEEF,   0, 0, 0, 32'h0,        3);
        vt[3] = mk(1, 32'h2001, 2'd0, 32'h0,      0, 0, 0, 32'h000000BE, 3);
        vt[4] = mk(1, 32'h2000, 2'd1, 32'h0,      0, 0, 0, 32'h0000BEEF, 4);
        vt[5] = mk(2, 32'h2010, 2'd2, 32'h12345678, 0, 0, 0, 32'h0,      5);
        vt[6] = mk(1, 32'h2010, 2'd2, 32'h0,      0, 2, 3, 32'h12345678, 9);
        vt[7] = mk(0, 32'h104,  2'd0, 32'h0,      3, 0, 0, 32'h00100593, 6);
        vt[8] = mk(0, 32'h104,  2'd0, 32'h0,      0, 0, 0, 32'h00100593, 1);
        vt[9] = mk(1, 32'h2000, 2'd3, 32'h0,      0, 0, 0, 32'h5958BEEF, 6);

        rst_in = 1'b0; rdy_in = 1'b1;
        if_req = 1'b0; if_addr = 32'h100; if_flush = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_width = '0; ls_wdata = '0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk1("rst if_ready", -1, if_ready, 1'b0);
        chk1("rst ls_ready", -1, ls_ready, 1'b0);
        chk1("rst ic_update", -1, ic_update, 1'b0);
        chk1("rst mem_wr", -1, mem_wr, 1'b0);
        chk32("rst mem_a", -1, mem_a, 32'h0);
        chk32("rst mem_dout", -1, {24'b0, mem_dout}, 32'h0);
        chk32("rst if_data", -1, if_data, 32'h0);
        chk32("rst ls_rdata", -1, ls_rdata, 32'h0);
        chk32("rst ic_update_addr", -1, ic_update_addr, 32'h0);
        chk32("rst ic_addr", -1, ic_addr, if_addr);
        @(posedge clk_in); #1;
        rst_in = 1'b1;

        for (int i = 0; i < 10; i++) run_txn(vt[i], i);

        // last grant was a load: a refetch hit hands priority back to the LSU
        run_txn(mk(0, 32'h100, 2'd0, 32'h0, 0, 0, 0, 32'h00000513, 1), 10);
        dual(11, 32'h108, 32'h51505352, 10, 32'h2001, 2'd0, 32'h000000BE, 3);
        // make the LSU the last grantee, then the fetch must win the tie
        run_txn(mk(1, 32'h2001, 2'd0, 32'h0, 0, 0, 0, 32'h000000BE, 3), 12);
        dual(13, 32'h10C, 32'h55545756, 6, 32'h2000, 2'd0, 32'h000000EF, 10);

        // fetch arriving with a flush while idle must be ignored
        if_req = 1'b1; if_addr = 32'h110; if_flush = 1'b1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            if (cyc == 3) begin if_req = 1'b0; if_flush = 1'b0; end
            @(negedge clk_in);
            chk1("idle flush if_ready", 14, if_ready, 1'b0);
            chk1("idle flush ic_update", 14, ic_update, 1'b0);
            @(posedge clk_in); #1;
        end
        $display("txn 14 flush while idle addr=110");

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            vec_t v;
            int   kind, n, st_at, st_len;
            kind = $urandom_range(0, 2);
            st_at = 0; st_len = 0;
            if ($urandom_range(0, 2) == 0) begin
                st_at  = $urandom_range(1, 2);
                st_len = $urandom_range(1, 3);
            end
            if (kind == 0) begin
                logic [31:0] a;
                bit hit;
                int fl;
                a = 32'h100 + 32'($urandom_range(0, 15) * 4);
                hit = ref_cached[a[7:2]];
                fl = (!hit && st_len == 0 && $urandom_range(0, 4) == 0) ? 3 : 0;
                if (hit) begin st_at = 0; st_len = 0; end
                v = mk(0, a, 2'd0, 32'h0, fl, st_at, st_len, ref_read(a, 4),
                       (hit ? 1 : 6) + st_len);
            end else begin
                logic [31:0] a;
                logic [1:0]  w;
                a = 32'h2000 + 32'($urandom_range(0, 250));
                w = 2'($urandom_range(0, 3));
                n = nbytes(w);
                if (kind == 1)
                    v = mk(1, a, w, 32'h0, 0, st_at, st_len, ref_read(a, n), n + 2 + st_len);
                else
                    v = mk(2, a, w, $urandom, 0, 0, 0, 32'h0, n + 1);
            end
            run_txn(v, 100 + i);
        end

`ifdef IFETCH_PERF_CNT_EN
        @(negedge clk_in);
        chk32("perf_hit", -2, perf_hit, 32'(n_hit));
        chk32("perf_miss", -2, perf_miss, 32'(n_miss));
        @(posedge clk_in); #1;
`endif

        // asynchronous reset in the middle of a refill aborts it silently
        if_req = 1'b1; if_addr = 32'h114;
        repeat (3) begin @(posedge clk_in); #1; end
        #2 rst_in = 1'b0;
        #1;
        chk32("abort mem_a", 15, mem_a, 32'h0);
        chk1("abort if_ready", 15, if_ready, 1'b0);
        if_req = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk_in);
            chk1("abort if_ready", 15, if_ready, 1'b0);
            chk1("abort ic_update", 15, ic_update, 1'b0);
            chk1("abort mem_wr", 15, mem_wr, 1'b0);
            @(posedge clk_in); #1;
        end
        $display("txn 15 reset abort addr=114");
`ifdef IFETCH_PERF_CNT_EN
        chk32("perf_miss after reset", 15, perf_miss, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
